// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - two-mode (1280x720 / 640x480) video raster timing generator
// Mode changes are applied only at the frame boundary; every output is a registered decode.
module video_timing_gen #(
  parameter int HCOUNT_W    = 11,
  parameter int VCOUNT_W    = 10,
  parameter int FC_MAX      = 60,
  parameter int M0_H_ACTIVE = 1280,
  parameter int M0_H_FP     = 110,
  parameter int M0_H_SYNC   = 40,
  parameter int M0_H_BP     = 220,
  parameter int M0_V_ACTIVE = 720,
  parameter int M0_V_FP     = 5,
  parameter int M0_V_SYNC   = 5,
  parameter int M0_V_BP     = 20,
  parameter int M1_H_ACTIVE = 640,
  parameter int M1_H_FP     = 16,
  parameter int M1_H_SYNC   = 96,
  parameter int M1_H_BP     = 48,
  parameter int M1_V_ACTIVE = 480,
  parameter int M1_V_FP     = 10,
  parameter int M1_V_SYNC   = 2,
  parameter int M1_V_BP     = 33
) (
  input  logic                      clk_pixel_in,
  input  logic                      rst_n_in,
  input  logic                      mode_in,
  output logic                      mode_out,
  output logic [HCOUNT_W-1:0]       hcount_out,
  output logic [VCOUNT_W-1:0]       vcount_out,
  output logic                      hs_out,
  output logic                      vs_out,
  output logic                      ad_out,
  output logic                      nf_out,
  output logic [$clog2(FC_MAX)-1:0] fc_out
);

  localparam int FC_W = $clog2(FC_MAX);

  typedef logic [HCOUNT_W-1:0] h_t;
  typedef logic [VCOUNT_W-1:0] v_t;
  typedef logic [FC_W-1:0]     fc_t;

  localparam h_t M0_HA  = h_t'(M0_H_ACTIVE);
  localparam h_t M0_HSS = h_t'(M0_H_ACTIVE + M0_H_FP);
  localparam h_t M0_HSE = h_t'(M0_H_ACTIVE + M0_H_FP + M0_H_SYNC);
  localparam h_t M0_HL  = h_t'(M0_H_ACTIVE + M0_H_FP + M0_H_SYNC + M0_H_BP - 1);
  localparam v_t M0_VA  = v_t'(M0_V_ACTIVE);
  localparam v_t M0_VSS = v_t'(M0_V_ACTIVE + M0_V_FP);
  localparam v_t M0_VSE = v_t'(M0_V_ACTIVE + M0_V_FP + M0_V_SYNC);
  localparam v_t M0_VL  = v_t'(M0_V_ACTIVE + M0_V_FP + M0_V_SYNC + M0_V_BP - 1);
  localparam h_t M1_HA  = h_t'(M1_H_ACTIVE);
  localparam h_t M1_HSS = h_t'(M1_H_ACTIVE + M1_H_FP);
  localparam h_t M1_HSE = h_t'(M1_H_ACTIVE + M1_H_FP + M1_H_SYNC);
  localparam h_t M1_HL  = h_t'(M1_H_ACTIVE + M1_H_FP + M1_H_SYNC + M1_H_BP - 1);
  localparam v_t M1_VA  = v_t'(M1_V_ACTIVE);
  localparam v_t M1_VSS = v_t'(M1_V_ACTIVE + M1_V_FP);
  localparam v_t M1_VSE = v_t'(M1_V_ACTIVE + M1_V_FP + M1_V_SYNC);
  localparam v_t M1_VL  = v_t'(M1_V_ACTIVE + M1_V_FP + M1_V_SYNC + M1_V_BP - 1);
  localparam fc_t FC_LAST = fc_t'(FC_MAX - 1);

  // Raster state
  h_t  hc_q, hc_d;
  v_t  vc_q, vc_d;
  logic mode_q, mode_d;
  fc_t fc_q, fc_d;

  // Registered outputs
  h_t   hcount_q;
  v_t   vcount_q;
  logic mode_out_q;
  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic ad_q, ad_d;
  logic nf_q, nf_d;

  h_t   h_act, h_ss, h_se, h_last;
  v_t   v_act, v_ss, v_se, v_last;
  logic h_wrap, v_wrap, hs_on, vs_on;

  always_comb begin
    h_act  = mode_q ? M1_HA  : M0_HA;
    h_ss   = mode_q ? M1_HSS : M0_HSS;
    h_se   = mode_q ? M1_HSE : M0_HSE;
    h_last = mode_q ? M1_HL  : M0_HL;
    v_act  = mode_q ? M1_VA  : M0_VA;
    v_ss   = mode_q ? M1_VSS : M0_VSS;
    v_se   = mode_q ? M1_VSE : M0_VSE;
    v_last = mode_q ? M1_VL  : M0_VL;

    // >= keeps the counters bounded even if they were somehow past the end
    h_wrap = (hc_q >= h_last);
    v_wrap = (vc_q >= v_last);

    hc_d   = h_wrap ? '0 : hc_q + 1'b1;
    vc_d   = vc_q;
    mode_d = mode_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + 1'b1;
      if (v_wrap) begin
        mode_d = mode_in;
      end
    end

    ad_d  = (hc_q < h_act) && (vc_q < v_act);
    hs_on = (hc_q >= h_ss) && (hc_q < h_se);
    vs_on = (vc_q >= v_ss) && (vc_q < v_se);
    // Mode 1 syncs are active-low
    hs_d  = mode_q ? ~hs_on : hs_on;
    vs_d  = mode_q ? ~vs_on : vs_on;
    nf_d  = (hc_q == h_act) && (vc_q == v_act);

    fc_d = fc_q;
    if (nf_d) begin
      fc_d = (fc_q == FC_LAST) ? '0 : fc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hc_q       <= '0;
      vc_q       <= '0;
      mode_q     <= 1'b0;
      fc_q       <= '0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      mode_out_q <= 1'b0;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      ad_q       <= 1'b0;
      nf_q       <= 1'b0;
    end else begin
      hc_q       <= hc_d;
      vc_q       <= vc_d;
      mode_q     <= mode_d;
      fc_q       <= fc_d;
      hcount_q   <= hc_q;
      vcount_q   <= vc_q;
      mode_out_q <= mode_q;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      ad_q       <= ad_d;
      nf_q       <= nf_d;
    end
  end

  assign mode_out   = mode_out_q;
  assign hcount_out = hcount_q;
  assign vcount_out = vcount_q;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;
  // fc_q advances on the same edge that raises nf_out, so it is already aligned
  assign fc_out     = fc_q;

endmodule
